// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame constants for the SPI burst register slave.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DISCARD} state_e;
  localparam int CMD_W = 8;
  localparam logic [7:0] CMD_WR_DEF = 8'hA2;
  localparam logic [7:0] CMD_RD_DEF = 8'hA3;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises the SPI pins into clk_osc and flags spi_clk / CS edges.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_osc,
  input  logic rst_n,
  input  logic spi_cs,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic mosi_s,
  output logic clk_rise,
  output logic clk_fall,
  output logic cs_rise,
  output logic cs_fall
);
  logic [SYNC_STAGES-1:0] cs_q, clk_q, mosi_q;
  logic cs_dly_q, clk_dly_q;
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      cs_q      <= '1;
      clk_q     <= '0;
      mosi_q    <= '0;
      cs_dly_q  <= 1'b1;
      clk_dly_q <= 1'b0;
    end else begin
      cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      clk_q     <= {clk_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      cs_dly_q  <= cs_q[SYNC_STAGES-1];
      clk_dly_q <= clk_q[SYNC_STAGES-1];
    end
  end
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign clk_rise = clk_q[SYNC_STAGES-1] & ~clk_dly_q;
  assign clk_fall = ~clk_q[SYNC_STAGES-1] & clk_dly_q;
  assign cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_dly_q;
  assign cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_dly_q;
endmodule

// File: rtl/spi_burst_reg_slave.sv
// spi_burst_reg_slave: oversampled SPI mode-0 slave, cmd + addr + auto-incrementing data burst.
// Optional SPI_STATUS_EN adds status_in, shifted out on MISO during the command byte.
module spi_burst_reg_slave
  import spi_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] CMD_WR = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD = CMD_RD_DEF
) (
  input  logic          clk_osc,
  input  logic          rst_n,
  input  logic          spi_cs,
  input  logic          spi_clk,
  input  logic          spi_mosi,
`ifdef SPI_STATUS_EN
  input  logic [7:0]    status_in,
`endif
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic [AW-1:0] reg_addr,
  output logic          reg_wr_en,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_rd_en,
  input  logic [DW-1:0] reg_rdata,
  output logic          busy,
  output logic          frame_err
);
  localparam int SW = (AW > DW) ? ((AW > CMD_W) ? AW : CMD_W) : ((DW > CMD_W) ? DW : CMD_W);
  localparam int CW = $clog2(SW);
  logic mosi_s, clk_rise, clk_fall, cs_rise, cs_fall;
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_osc(clk_osc), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .mosi_s(mosi_s), .clk_rise(clk_rise), .clk_fall(clk_fall), .cs_rise(cs_rise), .cs_fall(cs_fall)
  );
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-2:0] sh_q, sh_d;
  logic [SW-1:0] nxt;
  logic [DW-1:0] tx_q, tx_d, wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, ld_q, ld_d, rd_q, rd_d;
  logic busy_q, busy_d, err_q, err_d, miso_q, miso_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    ld_d    = rd_en_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    miso_d  = miso_q;
    nxt     = {sh_q, mosi_s};
    if (wr_en_q) addr_d = addr_q + 1'b1;
    if (ld_q) tx_d = reg_rdata;
    // CS rise wins over any coincident spi_clk edge
    if (cs_rise) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      miso_d  = 1'b0;
      err_d   = (state_q inside {CMD, ADDR}) || ((state_q inside {WDATA, RDATA}) && cnt_q != '0);
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SPI_STATUS_EN
          miso_d  = status_in[7];
          tx_d    = DW'({status_in[6:0], 1'b0}) << (DW - 8);
`endif
        end
        CMD: begin
          if (clk_rise) begin
            sh_d  = nxt[SW-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(CMD_W - 1)) begin
              cnt_d   = '0;
              rd_d    = nxt[7:0] == CMD_RD;
              state_d = (nxt[7:0] == CMD_WR || nxt[7:0] == CMD_RD) ? ADDR : DISCARD;
              err_d   = !(nxt[7:0] == CMD_WR || nxt[7:0] == CMD_RD);
            end
          end
`ifdef SPI_STATUS_EN
          if (clk_fall) begin
            miso_d = tx_q[DW-1];
            tx_d   = tx_q << 1;
          end
`endif
        end
        ADDR: if (clk_rise) begin
          sh_d  = nxt[SW-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(AW - 1)) begin
            cnt_d   = '0;
            addr_d  = nxt[AW-1:0];
            rd_en_d = rd_q;
            state_d = rd_q ? RDATA : WDATA;
            miso_d  = 1'b0;
          end
        end
        WDATA: if (clk_rise) begin
          sh_d  = nxt[SW-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d   = '0;
            wdata_d = nxt[DW-1:0];
            wr_en_d = 1'b1;
          end
        end
        RDATA: begin
          // prefetch the next word on the last rise so its MSB is ready for the next fall
          if (clk_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
              cnt_d   = '0;
              addr_d  = addr_q + 1'b1;
              rd_en_d = 1'b1;
            end
          end
          if (clk_fall) begin
            miso_d = tx_q[DW-1];
            tx_d   = tx_q << 1;
          end
        end
        DISCARD: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      ld_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      miso_q  <= miso_d;
    end
  end
  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign reg_addr    = addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wdata   = wdata_q;
  assign reg_rd_en   = rd_en_q;
  assign busy        = busy_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_spi_burst_reg_slave.sv
// tb_spi_burst_reg_slave: directed SPI frames with queued expectations checked by pin/bus monitors.
module tb_spi_burst_reg_slave;
  localparam time HALF = 50ns;
`ifdef SPI_STATUS_EN
  localparam logic [7:0] EP = 8'hC3;
`else
  localparam logic [7:0] EP = 8'h00;
`endif
  logic clk_osc = 1'b0, rst_n = 1'b0, spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, busy, frame_err;
  logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
  logic [7:0] status_in = 8'hC3;
  logic [7:0] mem [256];
  logic [7:0] fb [8];
  logic [15:0] exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [7:0] exp_mi [$];
  logic [7:0] rx = 8'h00;
  int nb = 0, checks = 0, errors = 0, err_cnt = 0, e0 = 0;
  spi_burst_reg_slave dut (
    .clk_osc(clk_osc), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
`ifdef SPI_STATUS_EN
    .status_in(status_in),
`endif
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy),
    .frame_err(frame_err)
  );
  always #5ns clk_osc = ~clk_osc;
  always @(posedge clk_osc) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
    if (reg_wr_en) mem[reg_addr] <= reg_wdata;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk_osc) begin
    if (frame_err) err_cnt++;
    if (reg_wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", {reg_addr, reg_wdata}, 16'hxxxx === 16'h0);
      else chk("wr", {reg_addr, reg_wdata}, exp_wr.pop_front());
    end
    if (reg_rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", reg_addr, 256);
      else chk("rd_addr", reg_addr, exp_rd.pop_front());
    end
  end
  always @(posedge spi_clk or negedge spi_cs) begin
    if (spi_clk && !spi_cs) begin
      rx = {rx[6:0], spi_miso};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_mi.size() == 0) chk("miso_unexpected", rx, 256);
        else chk("miso_byte", rx, exp_mi.pop_front());
      end
    end else if (!spi_clk) nb = 0;
  end
  task automatic cs_low();
    spi_cs = 1'b0;
    #HALF;
    chk("busy_in_frame", busy, 1);
  endtask
  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = fb[i / 8][7 - (i % 8)];
      #HALF spi_clk = 1'b1;
      #HALF spi_clk = 1'b0;
    end
  endtask
  task automatic cs_high();
    #HALF spi_cs = 1'b1;
    #300ns;
    chk("busy_after", busy, 0);
  endtask
  task automatic frame(input int n, input int exp_err);
    e0 = err_cnt;
    cs_low();
    send_bits(n);
    cs_high();
    chk("frame_err", err_cnt - e0, exp_err);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    #25ns;
    chk("reset_outputs", {spi_miso, spi_miso_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy, frame_err}, 0);
    rst_n = 1'b1;
    #100ns;
    fb[0] = 8'hA2; fb[1] = 8'h06; fb[2] = 8'hAB;
    exp_wr.push_back(16'h06AB);
    exp_mi.push_back(EP); exp_mi.push_back(8'h00); exp_mi.push_back(8'h00);
    frame(24, 0);
    fb[0] = 8'hA3; fb[1] = 8'h06; fb[2] = 8'h00;
    exp_rd.push_back(8'h06); exp_rd.push_back(8'h07);
    exp_mi.push_back(EP); exp_mi.push_back(8'h00); exp_mi.push_back(8'hAB);
    frame(24, 0);
    fb[0] = 8'hA2; fb[1] = 8'hFE; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33; fb[5] = 8'h44;
    exp_wr.push_back(16'hFE11); exp_wr.push_back(16'hFF22);
    exp_wr.push_back(16'h0033); exp_wr.push_back(16'h0144);
    exp_mi.push_back(EP);
    for (int i = 0; i < 5; i++) exp_mi.push_back(8'h00);
    frame(48, 0);
    fb[0] = 8'hA3; fb[1] = 8'h10; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00;
    exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'h12); exp_rd.push_back(8'h13);
    exp_mi.push_back(EP); exp_mi.push_back(8'h00);
    exp_mi.push_back(8'h4A); exp_mi.push_back(8'h4B); exp_mi.push_back(8'h48);
    frame(40, 0);
    fb[0] = 8'hA2; fb[1] = 8'h20; fb[2] = 8'h77;
    exp_mi.push_back(EP);
    frame(13, 1);
    fb[0] = 8'h55; fb[1] = 8'h06; fb[2] = 8'hAB;
    exp_mi.push_back(EP); exp_mi.push_back(8'h00); exp_mi.push_back(8'h00);
    frame(24, 1);
    fb[0] = 8'hA2; fb[1] = 8'h06; fb[2] = 8'hEE;
    exp_mi.push_back(EP); exp_mi.push_back(8'h00);
    cs_low();
    send_bits(20);
    rst_n = 1'b0;
    #1ns;
    chk("reset_midframe", {spi_miso, spi_miso_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy, frame_err}, 0);
    spi_cs = 1'b1;
    #100ns rst_n = 1'b1;
    #200ns;
    fb[0] = 8'hA2; fb[1] = 8'h06; fb[2] = 8'hCD;
    exp_wr.push_back(16'h06CD);
    exp_mi.push_back(EP); exp_mi.push_back(8'h00); exp_mi.push_back(8'h00);
    frame(24, 0);
    #1us;
    chk("wr_pending", exp_wr.size(), 0);
    chk("rd_pending", exp_rd.size(), 0);
    chk("miso_pending", exp_mi.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
